// File: rtl/cordic_axil_pkg.sv
// Register map, control/status bit positions and AXI response codes shared by
// the CORDIC AXI4-Lite register bank and its slave port.
package cordic_axil_pkg;

    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_ARG0     = 2;
    localparam int REG_ARG1     = 3;
    localparam int REG_RES0     = 4;
    localparam int REG_RES1     = 5;
    localparam int REG_SCRATCH0 = 6;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_DONE  = 1;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_slave_port.sv
// AXI4-Lite handshake engine: turns bus transactions into single-cycle register
// write/read strobes with decoded index and out-of-range flags.
module axil_slave_port
    import cordic_axil_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 6,
    parameter int NR = 8,
    localparam int IW = $clog2(NR),
    localparam int SW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] awaddr,
    input  logic          awvalid,
    output logic          awready,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] wstrb,
    input  logic          wvalid,
    output logic          wready,
    output logic [1:0]    bresp,
    output logic          bvalid,
    input  logic          bready,
    input  logic [AW-1:0] araddr,
    input  logic          arvalid,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic [1:0]    rresp,
    output logic          rvalid,
    input  logic          rready,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic [DW-1:0] wr_data,
    output logic [SW-1:0] wr_strb,
    output logic          wr_oor,
    output logic          rd_en,
    output logic [IW-1:0] rd_idx,
    output logic          rd_oor,
    input  logic [DW-1:0] rd_data
);

    localparam int LSB = $clog2(SW);
    localparam int HI  = LSB + IW;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ACK  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0]    w_state_q, w_state_d;
    logic [1:0]    r_state_q, r_state_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;

    assign wr_idx  = awaddr[LSB +: IW];
    assign wr_oor  = (awaddr >> HI) != '0;
    assign wr_data = wdata;
    assign wr_strb = wstrb;
    assign rd_idx  = araddr[LSB +: IW];
    assign rd_oor  = (araddr >> HI) != '0;

    assign awready = (w_state_q == W_ACK);
    assign wready  = (w_state_q == W_ACK);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;
    assign arready = (r_state_q == R_ACK);
    assign rvalid  = (r_state_q == R_DATA);
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    // READY is only raised once both address and data are present, so the
    // handshake always completes in the ACK cycle without any skid storage.
    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid && wvalid) w_state_d = W_ACK;
            W_ACK: begin
                if (awvalid && wvalid) begin
                    wr_en     = 1'b1;
                    bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid) r_state_d = R_ACK;
            R_ACK: begin
                if (arvalid) begin
                    rd_en     = 1'b1;
                    rdata_d   = rd_oor ? '0 : rd_data;
                    rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/cordic_axil_regs.sv
// AXI4-Lite register bank fronting the CORDIC core: argument/scratch registers,
// start pulse, busy/done status with W1C done, result capture and interrupt.
module cordic_axil_regs
    import cordic_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            core_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   core_arg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   core_arg1,
    input  logic                            core_done,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_res0,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_res1,
    output logic                            irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(C_NUM_REGS);

    localparam logic [IW-1:0] IDX_CTRL   = IW'(REG_CTRL);
    localparam logic [IW-1:0] IDX_STATUS = IW'(REG_STATUS);
    localparam logic [IW-1:0] IDX_ARG0   = IW'(REG_ARG0);
    localparam logic [IW-1:0] IDX_ARG1   = IW'(REG_ARG1);
    localparam logic [IW-1:0] IDX_RES0   = IW'(REG_RES0);
    localparam logic [IW-1:0] IDX_RES1   = IW'(REG_RES1);

    logic [DW-1:0] regs_q [C_NUM_REGS];
    logic [DW-1:0] regs_d [C_NUM_REGS];
    logic          core_start_q, core_start_d;
    logic          irq_q, irq_d;

    logic          wr_en, wr_oor, rd_oor, rd_en_unused;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] wr_data, rd_data;
    logic [SW-1:0] wr_strb;
    logic          unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    axil_slave_port #(
        .DW (DW),
        .AW (C_S_AXI_ADDR_WIDTH),
        .NR (C_NUM_REGS)
    ) u_port (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .araddr  (S_AXI_ARADDR),
        .arvalid (S_AXI_ARVALID),
        .arready (S_AXI_ARREADY),
        .rdata   (S_AXI_RDATA),
        .rresp   (S_AXI_RRESP),
        .rvalid  (S_AXI_RVALID),
        .rready  (S_AXI_RREADY),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_oor  (wr_oor),
        .rd_en   (rd_en_unused),
        .rd_idx  (rd_idx),
        .rd_oor  (rd_oor),
        .rd_data (rd_data)
    );

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // START is never stored, so CTRL bit0 reads back as zero; statement order
    // makes a core_done capture override a same-cycle DONE clear.
    always_comb begin
        regs_d       = regs_q;
        core_start_d = 1'b0;
        if (wr_en && !wr_oor) begin
            case (wr_idx)
                IDX_CTRL: begin
                    if (wr_strb[0]) begin
                        regs_d[IDX_CTRL][CTRL_IRQ_EN] = wr_data[CTRL_IRQ_EN];
                        core_start_d = wr_data[CTRL_START] && !regs_q[IDX_STATUS][STATUS_BUSY];
                    end
                end
                IDX_STATUS: begin
                    if (wr_strb[0] && wr_data[STATUS_DONE]) regs_d[IDX_STATUS][STATUS_DONE] = 1'b0;
                end
                IDX_RES0, IDX_RES1: ;
                default: regs_d[wr_idx] = merge_bytes(regs_q[wr_idx], wr_data, wr_strb);
            endcase
        end
        if (core_start_d) regs_d[IDX_STATUS][STATUS_BUSY] = 1'b1;
        if (core_done) begin
            regs_d[IDX_RES0] = core_res0;
            regs_d[IDX_RES1] = core_res1;
            regs_d[IDX_STATUS][STATUS_BUSY] = 1'b0;
            regs_d[IDX_STATUS][STATUS_DONE] = 1'b1;
        end
        irq_d = regs_d[IDX_STATUS][STATUS_DONE] & regs_d[IDX_CTRL][CTRL_IRQ_EN];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            core_start_q <= core_start_d;
            irq_q        <= irq_d;
        end
    end

    assign rd_data    = regs_q[rd_idx];
    assign core_start = core_start_q;
    assign core_arg0  = regs_q[IDX_ARG0];
    assign core_arg1  = regs_q[IDX_ARG1];
    assign irq        = irq_q;

endmodule

// File: tb/tb_cordic_axil_regs.sv
// Self-checking bench for cordic_axil_regs: table-driven register accesses with
// a response scoreboard, plus hand sequences for the core handshake and stalls.
`timescale 1ns/1ps
module tb_cordic_axil_regs;
    import cordic_axil_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        core_start, core_done, irq;
    logic [31:0] core_arg0, core_arg1, core_res0, core_res1;

    always #5 clk = ~clk;

    cordic_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .C_NUM_REGS         (8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (reset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .core_start    (core_start),
        .core_arg0     (core_arg0),
        .core_arg1     (core_arg1),
        .core_done     (core_done),
        .core_res0     (core_res0),
        .core_res1     (core_res1),
        .irq           (irq)
    );

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   failed = 0;
    int   start_pulses = 0;
    int   wide_pulses = 0;
    logic start_prev = 1'b0;
    logic start_at_resp;

    // Count start pulses on the falling edge so the DUT flops have settled
    always @(negedge clk) begin
        if (core_start) begin
            start_pulses++;
            if (start_prev) wide_pulses++;
        end
        start_prev = core_start;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit w, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] ed, logic [1:0] er);
        vec_t v;
        v.is_write = w;
        v.addr     = a;
        v.data     = d;
        v.strb     = s;
        v.exp_data = ed;
        v.exp_resp = er;
        return v;
    endfunction

    // One complete AXI transaction; expectation is queued before driving and
    // popped when the response channel fires.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        int   n;
        e.data = v.exp_data;
        e.resp = v.exp_resp;
        sb_q.push_back(e);
        if (v.is_write) begin
            awaddr = v.addr; wdata = v.data; wstrb = v.strb;
            awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
            n = 0;
            while (!awready && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput({name, "_awready"}, awready, 1);
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
            start_at_resp = core_start;
            n = 0;
            while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput({name, "_bvalid"}, bvalid, 1);
            e = sb_q.pop_front();
            checkOutput({name, "_bresp"}, bresp, e.resp);
            @(posedge clk); #1;
            bready = 1'b0;
        end else begin
            araddr = v.addr; arvalid = 1'b1; rready = 1'b1;
            n = 0;
            while (!arready && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput({name, "_arready"}, arready, 1);
            @(posedge clk); #1;
            arvalid = 1'b0;
            n = 0;
            while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput({name, "_rvalid"}, rvalid, 1);
            e = sb_q.pop_front();
            checkOutput({name, "_rdata"}, rdata, e.data);
            checkOutput({name, "_rresp"}, rresp, e.resp);
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic pulseDone(input logic [31:0] r0, input logic [31:0] r1);
        core_done = 1'b1; core_res0 = r0; core_res1 = r1;
        @(posedge clk); #1;
        core_done = 1'b0; core_res0 = 32'h0; core_res1 = 32'h0;
    endtask

    initial begin
        vec_t vecs[$];
        int   n;
        logic stable;
        logic [31:0] held_rdata;

        vecs.push_back(mk(1, 6'h08, 32'h0000_0001, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 6'h0C, 32'h0000_0002, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 6'h18, 32'h0000_0003, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 6'h1C, 32'h0000_0004, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(0, 6'h08, 32'h0, 4'h0, 32'h0000_0001, RESP_OKAY));
        vecs.push_back(mk(0, 6'h0C, 32'h0, 4'h0, 32'h0000_0002, RESP_OKAY));
        vecs.push_back(mk(0, 6'h18, 32'h0, 4'h0, 32'h0000_0003, RESP_OKAY));
        vecs.push_back(mk(0, 6'h1C, 32'h0, 4'h0, 32'h0000_0004, RESP_OKAY));
        vecs.push_back(mk(1, 6'h08, 32'hAABB_CCDD, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 6'h08, 32'h1122_3344, 4'h5, 32'h0, RESP_OKAY));
        vecs.push_back(mk(0, 6'h08, 32'h0, 4'h0, 32'hAA22_CC44, RESP_OKAY));
        vecs.push_back(mk(1, 6'h20, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_SLVERR));
        vecs.push_back(mk(0, 6'h20, 32'h0, 4'h0, 32'h0, RESP_SLVERR));
        vecs.push_back(mk(0, 6'h3C, 32'h0, 4'h0, 32'h0, RESP_SLVERR));
        vecs.push_back(mk(0, 6'h00, 32'h0, 4'h0, 32'h0, RESP_OKAY));
        vecs.push_back(mk(0, 6'h04, 32'h0, 4'h0, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 6'h10, 32'h0000_FFFF, 4'hF, 32'h0, RESP_OKAY));
        vecs.push_back(mk(0, 6'h10, 32'h0, 4'h0, 32'h0, RESP_OKAY));
        vecs.push_back(mk(0, 6'h08, 32'h0, 4'h0, 32'hAA22_CC44, RESP_OKAY));

        reset = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        core_done = 0; core_res0 = '0; core_res1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {awready, wready, arready}, 3'b000);
        checkOutput("rst_valid", {bvalid, rvalid}, 2'b00);
        checkOutput("rst_core_start_irq", {core_start, irq}, 2'b00);
        checkOutput("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
        checkOutput("rst_args", {core_arg0, core_arg1}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
        checkOutput("core_arg0", core_arg0, 32'hAA22_CC44);
        checkOutput("core_arg1", core_arg1, 32'h0000_0002);

        applyStimulus(mk(1, 6'h00, 32'h3, 4'hF, 32'h0, RESP_OKAY), "ctrl_start");
        checkOutput("start_at_resp", start_at_resp, 1);
        checkOutput("start_pulses_1", start_pulses, 1);
        applyStimulus(mk(0, 6'h04, 32'h0, 4'h0, 32'h1, RESP_OKAY), "status_busy");
        applyStimulus(mk(0, 6'h00, 32'h0, 4'h0, 32'h2, RESP_OKAY), "ctrl_rd");
        applyStimulus(mk(1, 6'h00, 32'h3, 4'hF, 32'h0, RESP_OKAY), "ctrl_start_busy");
        checkOutput("start_busy_ignored", start_at_resp, 0);
        checkOutput("start_pulses_still_1", start_pulses, 1);
        checkOutput("irq_while_busy", irq, 0);

        pulseDone(32'h1234, 32'h5678);
        checkOutput("irq_after_done", irq, 1);
        applyStimulus(mk(0, 6'h10, 32'h0, 4'h0, 32'h1234, RESP_OKAY), "res0");
        applyStimulus(mk(0, 6'h14, 32'h0, 4'h0, 32'h5678, RESP_OKAY), "res1");
        applyStimulus(mk(0, 6'h04, 32'h0, 4'h0, 32'h2, RESP_OKAY), "status_done");
        applyStimulus(mk(1, 6'h04, 32'h2, 4'hF, 32'h0, RESP_OKAY), "status_w1c");
        applyStimulus(mk(0, 6'h04, 32'h0, 4'h0, 32'h0, RESP_OKAY), "status_cleared");
        checkOutput("irq_cleared", irq, 0);

        pulseDone(32'h9, 32'hA);
        checkOutput("irq_idle_done", irq, 1);
        applyStimulus(mk(0, 6'h04, 32'h0, 4'h0, 32'h2, RESP_OKAY), "status_idle_done");
        applyStimulus(mk(0, 6'h10, 32'h0, 4'h0, 32'h9, RESP_OKAY), "res0_idle_done");
        checkOutput("no_wide_start", wide_pulses, 0);

        // Stall both response channels with new requests still pending
        awaddr = 6'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        araddr = 6'h08; arvalid = 1; rready = 0;
        n = 0;
        while (!(bvalid && rvalid) && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("hold_bvalid", bvalid, 1);
        checkOutput("hold_rvalid", rvalid, 1);
        checkOutput("hold_rdata_first", rdata, 32'hAA22_CC44);
        held_rdata = rdata;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bvalid || !rvalid || rdata !== held_rdata || awready || wready || arready) stable = 1'b0;
        end
        checkOutput("hold_stable", stable, 1);
        checkOutput("hold_write_landed", core_arg1, 32'h55);

        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_valid", {bvalid, rvalid}, 2'b00);
        checkOutput("midrst_ready", {awready, wready, arready}, 3'b000);
        checkOutput("midrst_start_irq", {core_start, irq}, 2'b00);
        checkOutput("midrst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
        checkOutput("midrst_args", {core_arg0, core_arg1}, 64'h0);
        awvalid = 0; wvalid = 0; arvalid = 0;
        reset = 1'b0;
        @(posedge clk); #1;
        applyStimulus(mk(0, 6'h18, 32'h0, 4'h0, 32'h0, RESP_OKAY), "post_rst_scratch");
        applyStimulus(mk(0, 6'h04, 32'h0, 4'h0, 32'h0, RESP_OKAY), "post_rst_status");
        applyStimulus(mk(0, 6'h10, 32'h0, 4'h0, 32'h0, RESP_OKAY), "post_rst_res0");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cordic_axil_regs.md
# cordic_axil_regs

Parametrised AXI4-Lite slave register bank that fronts the CORDIC rotation core. It generalises the four-register read/write peripheral to N registers and adds byte strobes, read-only result registers, a self-clearing start pulse, busy/done status and an interrupt. It sits between the PS AXI interconnect and the CORDIC datapath inside the block-design wrapper.

## Interface
- C_S_AXI_DATA_WIDTH, 32, register and bus width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be ≥ clog2(C_NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8).
- C_NUM_REGS, 8, register count; power of two, ≥ 8.
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DW/DW/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DW/2/1/1  read data.
- core_start  out  1  one-cycle start pulse to CORDIC core.
- core_arg0, core_arg1  out  DW  ARG0/ARG1 register contents.
- core_done  in  1  one-cycle completion pulse from core.
- core_res0, core_res1  in  DW  core results, valid in core_done cycle.
- irq  out  1  level interrupt.

## Operation
- Register index = addr[clog2(DW/8) +: clog2(C_NUM_REGS)]; addr bits above that range nonzero → out of range.
- Map: 0 CTRL (bit0 START write-1 pulse, reads 0; bit1 IRQ_EN RW), 1 STATUS RO (bit0 BUSY, bit1 DONE), 2 ARG0 RW, 3 ARG1 RW, 4 RES0 RO, 5 RES1 RO, 6..C_NUM_REGS-1 scratch RW.
- Writes honour WSTRB per byte; RW bits only.
- STATUS.DONE: write 1 to bit1 of STATUS clears it (W1C); all other STATUS/RES writes ignored, BRESP OKAY.
- START=1 written while BUSY=0 → core_start high next cycle for exactly one cycle, BUSY set same cycle. START while BUSY=1 ignored.
- core_done → RES0/RES1 captured, BUSY cleared, DONE set, next cycle. core_done while BUSY=0 still captures and sets DONE.
- DONE set and W1C in same cycle: set wins.
- irq = DONE & IRQ_EN, registered.
- Out-of-range: write discarded, BRESP SLVERR (2'b10); read RDATA 0, RRESP SLVERR. In-range always OKAY.

## Timing
- Reset: AWREADY, WREADY, ARREADY, BVALID, RVALID, core_start, irq = 0; BRESP, RRESP, RDATA = 0; all registers 0.
- Write: AWREADY and WREADY asserted together for one cycle when AWVALID & WVALID & !BVALID; register updates that edge; BVALID next cycle, held until BREADY. No address/data skid: one-sided VALID waits.
- Read: ARREADY one-cycle pulse when ARVALID & !RVALID; RDATA/RRESP registered, RVALID next cycle, held stable until RREADY. One outstanding read, one outstanding write; read and write channels independent, may complete same cycle.
- Same-cycle AXI write to RES0/RES1 and core_done: capture wins (write is ignored anyway). Same-cycle read of RES during capture returns old value.
- Reset mid-transaction: all VALID/READY drop next edge; transaction lost, master retries.

## Structure
- Package cordic_axil_pkg: register index constants (REG_CTRL … REG_RES1, REG_SCRATCH0), CTRL/STATUS bit positions, RESP_OKAY/RESP_SLVERR.
- One sub-module, axil_slave_port: AXI4-Lite handshake FSM emitting wr_en/wr_idx/wr_data/wr_strb/wr_oor and rd_en/rd_idx/rd_oor, accepting rd_data; top holds register file and core logic.

## Test plan
- Write 0x1,0x2,0x3,0x4 to ARG0, ARG1, scratch6, scratch7, WSTRB 0xF → read back identical, RESP OKAY.
- Write 0xAABBCCDD to ARG0 then 0x11223344 with WSTRB 0x5 → reads 0xAA22CC44.
- Write CTRL=0x3 → core_start one cycle, STATUS=0x1; second START while busy → no pulse; core_done with res 0x1234/0x5678 → RES0/RES1 read those, STATUS=0x2, irq=1; write STATUS 0x2 → STATUS 0, irq 0.
- Write/read address 0x20 with C_NUM_REGS=8, DW=32 → BRESP/RRESP SLVERR, RDATA 0, no register changed.
- Hold BREADY/RREADY low 10 cycles → BVALID/RVALID, RDATA stable, no new AWREADY/ARREADY; assert reset mid-hold → all outputs 0 next cycle, registers 0.
